// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed seven-segment display controller.
package seg7_pkg;

  // Scan sequencer states: parked, anti-ghosting gap, lit portion, dark remainder.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEAD,
    ST_ON,
    ST_OFF
  } scan_state_t;

  // Segment patterns {g,f,e,d,c,b,a}, active high.
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  // Position of the decimal point in the 8-bit segment bus.
  localparam int SEG_DP = 7;

endpackage

// File: rtl/seg7_decode.sv
// Hex digit plus decimal point to seven-segment pattern, with a forced-dark override.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [4:0] code,
  input  logic       blank,
  output logic [7:0] seg
);

  // Look up the hex glyph, attach the dp bit, and suppress everything when blanked.
  always_comb begin
    seg = '0;
    case (code[3:0])
      4'h0: seg[6:0] = SEG_0;
      4'h1: seg[6:0] = SEG_1;
      4'h2: seg[6:0] = SEG_2;
      4'h3: seg[6:0] = SEG_3;
      4'h4: seg[6:0] = SEG_4;
      4'h5: seg[6:0] = SEG_5;
      4'h6: seg[6:0] = SEG_6;
      4'h7: seg[6:0] = SEG_7;
      4'h8: seg[6:0] = SEG_8;
      4'h9: seg[6:0] = SEG_9;
      4'hA: seg[6:0] = SEG_A;
      4'hB: seg[6:0] = SEG_B;
      4'hC: seg[6:0] = SEG_C;
      4'hD: seg[6:0] = SEG_D;
      4'hE: seg[6:0] = SEG_E;
      default: seg[6:0] = SEG_F;
    endcase
    seg[SEG_DP] = code[4];
    if (blank) begin
      seg = '0;
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed display scanner with a double-buffered digit file,
// frame-aligned commits, per-slot dead time and sixteen-step PWM brightness.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1024
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              enable,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [1:0]        wr_idx,
  input  logic [4:0]        wr_data,
  input  logic              wr_commit,
  input  logic [3:0]        brightness,
  input  logic              blank_lz,
  output logic [7:0]        seven_seg,
  output logic [DIGITS-1:0] digit_en,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int SUB = SCAN_DIV / 16;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [1:0] DIG_LAST = 2'(DIGITS - 1);

  scan_state_t state;
  logic [CNT_W-1:0] slot_cnt;
  logic [1:0] dig;
  logic [4:0] shadow [DIGITS];
  logic [4:0] active [DIGITS];
  logic pending;
  logic slot_end;
  logic frame_end;
  logic commit_now;
  logic dim_next;
  logic [31:0] next_sixteenth;
  logic [DIGITS-1:0] lz_blank;
  logic lz_run;
  logic [7:0] seg_dec;

  assign wr_ready = ~pending;

  // Slot/frame boundaries and whether the next count falls past the PWM on-window.
  always_comb begin
    slot_end = 1'b0;
    frame_end = 1'b0;
    next_sixteenth = (32'(slot_cnt) + 32'd1) / 32'(SUB);
    dim_next = next_sixteenth > 32'(brightness);
    if ((state == ST_ON || state == ST_OFF) && slot_cnt == SLOT_LAST) begin
      slot_end = 1'b1;
      frame_end = (dig == DIG_LAST);
    end
    commit_now = pending && (!enable || frame_end);
  end

  // A digit is blanked only if it and every more significant digit hold a plain zero.
  always_comb begin
    lz_blank = '0;
    lz_run = blank_lz;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run = lz_run && (active[i] == 5'd0);
      lz_blank[i] = lz_run;
    end
  end

  seg7_decode u_decode (
    .code  (active[dig]),
    .blank (lz_blank[dig]),
    .seg   (seg_dec)
  );

  // Shadow writes, commit request latching, and frame-aligned copy into the active file.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      pending <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr_valid && wr_ready) begin
        shadow[wr_idx] <= wr_data;
      end
      if (commit_now) begin
        pending <= 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
          active[i] <= shadow[i];
        end
      end else if (wr_commit) begin
        pending <= 1'b1;
      end
    end
  end

  // Scan sequencer with registered outputs lagging the state by one cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      slot_cnt <= '0;
      dig <= '0;
      seven_seg <= '0;
      digit_en <= '0;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state <= ST_IDLE;
      slot_cnt <= '0;
      dig <= '0;
      seven_seg <= '0;
      digit_en <= '0;
      frame_done <= 1'b0;
    end else begin
      seven_seg <= (state == ST_ON) ? seg_dec : 8'h00;
      digit_en <= (state == ST_ON) ? (DIGITS'(1) << dig) : '0;
      frame_done <= frame_end;
      case (state)
        ST_IDLE: begin
          slot_cnt <= '0;
          dig <= '0;
          state <= ST_DEAD;
        end
        ST_DEAD: begin
          slot_cnt <= slot_cnt + 1'b1;
          state <= ST_ON;
        end
        ST_ON, ST_OFF: begin
          if (slot_end) begin
            slot_cnt <= '0;
            dig <= (dig == DIG_LAST) ? 2'd0 : dig + 2'd1;
            state <= ST_DEAD;
          end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (state == ST_ON && dim_next) begin
              state <= ST_OFF;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed self-checking bench for seg7_scan_ctrl at SCAN_DIV=1024.
// The cycle variable counts rising edges since reset was released.
module tb_seg7_scan_ctrl;

  logic clock = 1'b0;
  logic wb_rst_i;
  logic enable;
  logic wr_valid;
  logic wr_ready;
  logic [1:0] wr_idx;
  logic [4:0] wr_data;
  logic wr_commit;
  logic [3:0] brightness;
  logic blank_lz;
  logic [7:0] seven_seg;
  logic [3:0] digit_en;
  logic frame_done;

  int cycle = 0;
  int check_count = 0;
  int error_count = 0;

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  seg7_scan_ctrl #(
    .DIGITS   (4),
    .SCAN_DIV (1024)
  ) dut (
    .wb_clk_i   (clock),
    .wb_rst_i   (wb_rst_i),
    .enable     (enable),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .brightness (brightness),
    .blank_lz   (blank_lz),
    .seven_seg  (seven_seg),
    .digit_en   (digit_en),
    .frame_done (frame_done)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%02h expected 0x%02h at cycle %0d", tag, observed, expected, cycle);
    end
  endtask

  task automatic checkDigit(input string tag, input logic [3:0] en, input logic [7:0] seg);
    checkOutput({tag, "_en"}, {4'h0, digit_en}, {4'h0, en});
    checkOutput({tag, "_seg"}, seven_seg, seg);
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] idx, input logic [4:0] data, input logic commit);
    wr_valid = valid;
    wr_idx = idx;
    wr_data = data;
    wr_commit = commit;
  endtask

  // Advance to the falling edge after rising edge number target.
  task automatic stepTo(input int target);
    if (cycle < target) begin
      while (cycle < target) begin
        @(posedge clock);
        cycle++;
      end
      @(negedge clock);
    end
  endtask

  task automatic writeDigit(input logic [1:0] idx, input logic [4:0] data);
    applyStimulus(1'b1, idx, data, 1'b0);
    stepTo(cycle + 1);
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b0);
  endtask

  initial begin
    wb_rst_i = 1'b1;
    enable = 1'b0;
    brightness = 4'd15;
    blank_lz = 1'b0;
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    $display("[TB] reset state");
    checkDigit("rst", 4'b0000, 8'h00);
    checkOutput("rst_frame_done", {7'd0, frame_done}, 8'h00);
    checkOutput("rst_wr_ready", {7'd0, wr_ready}, 8'h01);

    // Basic scan of all-zero content.
    wb_rst_i = 1'b0;
    enable = 1'b1;
    cycle = 0;
    stepTo(1);    checkDigit("idle_out", 4'b0000, 8'h00);
    stepTo(2);    checkDigit("dead0", 4'b0000, 8'h00);
    stepTo(3);    checkDigit("d0_first", 4'b0001, 8'h3F);
    stepTo(1025); checkDigit("d0_last", 4'b0001, 8'h3F);
    stepTo(1026); checkDigit("dead1", 4'b0000, 8'h00);
    stepTo(1027); checkDigit("d1_first", 4'b0010, 8'h3F);
    stepTo(2051); checkDigit("d2_first", 4'b0100, 8'h3F);
    stepTo(3075); checkDigit("d3_first", 4'b1000, 8'h3F);
    stepTo(4096); checkOutput("fd_before", {7'd0, frame_done}, 8'h00);
    stepTo(4097); checkOutput("fd_frame1", {7'd0, frame_done}, 8'h01);
    stepTo(4098); checkOutput("fd_after", {7'd0, frame_done}, 8'h00);
    checkDigit("dead_f2", 4'b0000, 8'h00);
    stepTo(4099); checkDigit("d0_f2", 4'b0001, 8'h3F);

    // Writes then a mid-frame commit; a write while pending must be dropped.
    stepTo(5000);
    writeDigit(2'd0, 5'h05);
    writeDigit(2'd1, 5'h1A);
    checkOutput("ready_pre_commit", {7'd0, wr_ready}, 8'h01);
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b1);
    stepTo(5003);
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b0);
    checkOutput("ready_after_commit", {7'd0, wr_ready}, 8'h00);
    checkDigit("old_d0", 4'b0001, 8'h3F);
    stepTo(5010);
    writeDigit(2'd2, 5'h07);
    stepTo(6000); checkDigit("old_d1", 4'b0010, 8'h3F);
    checkOutput("ready_pending", {7'd0, wr_ready}, 8'h00);
    stepTo(8192); checkOutput("ready_pre_frame", {7'd0, wr_ready}, 8'h00);
    stepTo(8193); checkOutput("fd_frame2", {7'd0, frame_done}, 8'h01);
    checkOutput("ready_post_commit", {7'd0, wr_ready}, 8'h01);
    stepTo(8195); checkDigit("new_d0", 4'b0001, 8'h6D);
    stepTo(9219); checkDigit("new_d1", 4'b0010, 8'hF7);
    stepTo(10243); checkDigit("dropped_d2", 4'b0100, 8'h3F);

    // Brightness 3: lit for slot counts 1..255 only.
    brightness = 4'd3;
    stepTo(11267); checkDigit("pwm_first", 4'b1000, 8'h3F);
    stepTo(11521); checkDigit("pwm_last_on", 4'b1000, 8'h3F);
    stepTo(11522); checkDigit("pwm_first_off", 4'b0000, 8'h00);
    stepTo(12000); checkDigit("pwm_mid_off", 4'b0000, 8'h00);
    stepTo(12289); checkOutput("fd_from_off", {7'd0, frame_done}, 8'h01);

    // Leading-zero blanking with active = {0,0,7,0}.
    brightness = 4'd15;
    blank_lz = 1'b1;
    writeDigit(2'd0, 5'h00);
    writeDigit(2'd1, 5'h07);
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b1);
    stepTo(cycle + 1);
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b0);
    stepTo(16385); checkOutput("fd_frame4", {7'd0, frame_done}, 8'h01);
    stepTo(16387); checkDigit("lz_d0", 4'b0001, 8'h3F);
    stepTo(17411); checkDigit("lz_d1", 4'b0010, 8'h07);
    stepTo(18435); checkDigit("lz_d2", 4'b0100, 8'h00);
    stepTo(19459); checkDigit("lz_d3", 4'b1000, 8'h00);

    // Write+commit together, then drop enable mid-ON so the commit applies at once.
    stepTo(19500);
    applyStimulus(1'b1, 2'd2, 5'h09, 1'b1);
    stepTo(19501);
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b0);
    checkOutput("ready_wc", {7'd0, wr_ready}, 8'h00);
    stepTo(19510); checkDigit("pre_disable", 4'b1000, 8'h00);
    enable = 1'b0;
    stepTo(19511); checkDigit("disabled", 4'b0000, 8'h00);
    stepTo(19512); checkOutput("ready_disabled", {7'd0, wr_ready}, 8'h01);
    stepTo(19515);
    enable = 1'b1;
    blank_lz = 1'b0;
    stepTo(19516); checkDigit("re_idle", 4'b0000, 8'h00);
    stepTo(19517); checkDigit("re_dead", 4'b0000, 8'h00);
    stepTo(19518); checkDigit("re_d0", 4'b0001, 8'h3F);
    stepTo(21566); checkDigit("re_d2", 4'b0100, 8'h6F);
    stepTo(22590); checkDigit("re_d3", 4'b1000, 8'h3F);
    stepTo(23611); checkOutput("re_fd_before", {7'd0, frame_done}, 8'h00);
    stepTo(23612); checkOutput("re_fd", {7'd0, frame_done}, 8'h01);

    // Reset mid-frame with a commit pending.
    stepTo(23700);
    applyStimulus(1'b1, 2'd0, 5'h08, 1'b1);
    stepTo(23701);
    applyStimulus(1'b0, 2'd0, 5'd0, 1'b0);
    checkOutput("ready_pre_rst", {7'd0, wr_ready}, 8'h00);
    stepTo(23705);
    wb_rst_i = 1'b1;
    stepTo(23706);
    checkDigit("midrst", 4'b0000, 8'h00);
    checkOutput("midrst_fd", {7'd0, frame_done}, 8'h00);
    checkOutput("midrst_ready", {7'd0, wr_ready}, 8'h01);
    wb_rst_i = 1'b0;
    stepTo(23709); checkDigit("post_rst_d0", 4'b0001, 8'h3F);
    stepTo(24733); checkDigit("post_rst_d1", 4'b0010, 8'h3F);
    stepTo(25757); checkDigit("post_rst_d2", 4'b0100, 8'h3F);
    stepTo(27803); checkOutput("post_rst_fd", {7'd0, frame_done}, 8'h01);
    stepTo(27805); checkDigit("post_rst_f2_d0", 4'b0001, 8'h3F);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
